// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: producer handshake, register-file write port,
// forwarding lookup and occupancy.
interface wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_waddr;
  logic [DW-1:0] in_wdata;
  logic          wb_stall;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] q_raddr;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic [LW-1:0] level;

  modport slave (
    input  in_valid, in_waddr, in_wdata, wb_stall, q_raddr,
    output in_ready, we, waddr, wdata, q_hit, q_data, level
  );

  modport master (
    output in_valid, in_waddr, in_wdata, wb_stall, q_raddr,
    input  in_ready, we, waddr, wdata, q_hit, q_data, level
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back FIFO feeding the register file's single write port.
// Define WBQ_BYPASS_EN to build the youngest-match forwarding lookup.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [DW-1:0] w_qData;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  // Writes to r0 complete the handshake but are never stored.
  assign w_push  = bus.in_valid && !w_full && (bus.in_waddr != '0);
  assign w_pop   = !w_empty && !bus.wb_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wrPtr] <= bus.in_waddr;
        r_data[r_wrPtr] <= bus.in_wdata;
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign bus.in_ready = !w_full;
  assign bus.we       = w_pop;
  assign bus.waddr    = w_empty ? '0 : r_addr[r_rdPtr];
  assign bus.wdata    = w_empty ? '0 : r_data[r_rdPtr];
  assign bus.level    = r_level;

`ifdef WBQ_BYPASS_EN
  // Walk oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    w_hit   = 1'b0;
    w_qData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((LW'(k) < r_level) && (bus.q_raddr != '0) &&
          (r_addr[PW'(r_rdPtr + PW'(k))] == bus.q_raddr)) begin
        w_hit   = 1'b1;
        w_qData = r_data[PW'(r_rdPtr + PW'(k))];
      end
    end
  end
`else
  logic w_unusedRaddr;
  assign w_unusedRaddr = ^bus.q_raddr;
  assign w_hit         = 1'b0;
  assign w_qData       = '0;
`endif

  assign bus.q_hit  = w_hit;
  assign bus.q_data = w_qData;
endmodule
